muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised iterative RV32M multiply/divide unit. It supersedes the fixed-width m_extension block that hangs off the EX stage.
- Executes all eight M-extension funct3 operations.
- Multiply width per cycle is configurable.
- Divide special cases (divide-by-zero, signed overflow) resolve early.
- Provides a flush input so hazard detection can kill an in-flight op on mispredict.
- Sits beside EX. Its result is muxed into the EX_MEM alu input, and hazard detection stalls the pipe while busy.

Parameters:
XLEN, 32, operand/result width; must be even and ≥ 8.
MUL_STEP, 1, multiplier bits retired per cycle; must divide XLEN (legal: 1, 2, 4, 8).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
start  in  1  request; sampled only when state is IDLE or DONE
funct3  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  in  XLEN  rs1 operand
b  in  XLEN  rs2 operand
flush  in  1  abort current op
busy  out  1  op in progress (MUL or DIV state)
done  out  1  one-cycle result-valid pulse
result  out  XLEN  registered result; held until next accepted start or reset

Behaviour:
Reset (rst=0 at a clock edge, any state):
- State goes to IDLE.
- busy, done, result, counter, and all internal accumulators go to 0.
- Reset takes priority over flush and start.

States: IDLE, MUL, DIV, DONE.
- IDLE/DONE, start=1, flush=0: latch a, b, funct3, and the sign flags.
  - Signed ops (MULH/MULHSU a; MULH b; DIV/REM a and b) latch the absolute value of the operand and record the negate flag.
  - funct3[2]=0 goes to MUL with counter = XLEN/MUL_STEP.
  - funct3[2]=1 and b==0 goes straight to DONE with result = all-ones (DIV/DIVU) or a (REM/REMU).
  - DIV/REM with a = 0x8…0 and b = all-ones goes straight to DONE with result = 0x8…0 (DIV) or 0 (REM).
  - Otherwise funct3[2]=1 goes to DIV with counter = XLEN.
- IDLE/DONE, start=0: go to / stay in IDLE. done is asserted only in the cycle the state is DONE.
- MUL, each cycle: add (multiplicand × next MUL_STEP multiplier bits) into a 2·XLEN product accumulator, shift, decrement counter. When counter reaches 1, go to DONE.
- DIV, each cycle: restoring shift-subtract, one quotient bit per cycle, decrement counter. When counter reaches 1, go to DONE.
- Entering DONE: apply sign correction, then register result.
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits. The product is negated (2·XLEN two's complement) first if the sign flags differ.
  - DIV quotient is negated if a and b signs differ.
  - REM remainder takes the sign of a.
- Latency, start at cycle t:
  - done at t+XLEN/MUL_STEP+1 for multiplies (t+33 at defaults).
  - done at t+XLEN+1 for divides.
  - done at t+1 for special cases.
- Back-to-back: start accepted in the DONE cycle begins the next op, so done drops the following cycle.
- start while busy: ignored, no effect.
- flush=1 in MUL/DIV/DONE: next state is IDLE and done is not asserted. result keeps its old value (not updated by the killed op). flush takes priority over start in the same cycle.
- Operand changes after acceptance have no effect.

Decomposition:
- rv32i_types gains m_funct3_t: enum of the eight ops, 3 bits, encodings above.
- The state enum stays local to the module.
- One sub-module is natural: muldiv_step, a combinational per-cycle datapath.
  - Multiply mode: MUL_STEP partial-product add.
  - Divide mode: 1-bit restoring subtract.
  - Instantiated once.

Test Plan:
- XLEN=32, MUL_STEP=1. MUL a=7, b=0xFFFFFFFD (−3), start at t → busy t+1..t+32; done pulse only at t+33; result=0xFFFFFFEB.
- MULH a=b=0x80000000 → result 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD at t+33. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIV a=5, b=0 → done at t+1, result 0xFFFFFFFF. REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → done t+1, result 0x80000000. REM of the same operands → 0.
- MUL start at t, flush at t+10 → IDLE at t+11; no done in any cycle; result unchanged. New DIVU started at t+11 completes normally at t+44.
- MUL_STEP=4: MUL 0x12345678×0x10 → done at t+9, result 0x23456780.
- rst=0 asserted at t+5 mid-DIV → busy/done/result = 0 the following cycle. start pulses while busy are ignored (a second start at t+3 does not alter the result).

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// The funct3 encodings match the M-extension opcode map.
package muldiv_unit_pkg;

   typedef enum logic [2:0] {
      M_MUL    = 3'b000,
      M_MULH   = 3'b001,
      M_MULHSU = 3'b010,
      M_MULHU  = 3'b011,
      M_DIV    = 3'b100,
      M_DIVU   = 3'b101,
      M_REM    = 3'b110,
      M_REMU   = 3'b111
   } m_funct3_t;

   function automatic logic is_div_op(input m_funct3_t op);
      return op[2];
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// Combinational per-cycle datapath: a MUL_STEP-bit shift-add multiply step
// or a single restoring shift-subtract divide step on the {acc_hi, acc_lo} pair.
module muldiv_step
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MUL_STEP = 1
)(
   input  logic            div_mode,
   input  logic [XLEN-1:0] acc_hi,
   input  logic [XLEN-1:0] acc_lo,
   input  logic [XLEN-1:0] operand,
   output logic [XLEN-1:0] acc_hi_next,
   output logic [XLEN-1:0] acc_lo_next
);

   logic [XLEN+MUL_STEP-1:0] mcand_ext;
   logic [XLEN+MUL_STEP-1:0] mbits_ext;
   logic [XLEN+MUL_STEP-1:0] partial;
   logic [XLEN+MUL_STEP-1:0] sum;
   logic [XLEN+MUL_STEP-1:0] lo_cat;
   logic [XLEN:0]            shifted;
   logic [XLEN:0]            diff;
   logic                     fits;

   // Multiply: acc_lo holds the unconsumed multiplier bits; product bits shift in from the top.
   assign mcand_ext = {{MUL_STEP{1'b0}}, operand};
   assign mbits_ext = {{XLEN{1'b0}}, acc_lo[MUL_STEP-1:0]};
   assign partial   = mcand_ext * mbits_ext;
   assign sum       = {{MUL_STEP{1'b0}}, acc_hi} + partial;
   assign lo_cat    = {sum[MUL_STEP-1:0], acc_lo};

   // Divide: remainder < divisor, so the shifted value fits in XLEN+1 bits and diff's MSB is the borrow.
   assign shifted = {acc_hi, acc_lo[XLEN-1]};
   assign diff    = shifted - {1'b0, operand};
   assign fits    = ~diff[XLEN];

   always_comb begin
      acc_hi_next = sum[XLEN+MUL_STEP-1:MUL_STEP];
      acc_lo_next = lo_cat[XLEN+MUL_STEP-1:MUL_STEP];
      if (div_mode) begin
         acc_hi_next = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
         acc_lo_next = {acc_lo[XLEN-2:0], fits};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit beside EX: operates on operand magnitudes,
// resolves divide special cases at accept time, and fixes signs when entering DONE.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MUL_STEP = 1
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CNT_W      = $clog2(XLEN + 1);
   localparam int MUL_CYCLES = XLEN / MUL_STEP;
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t            state, state_next;
   m_funct3_t         op_in, op_q;
   logic [XLEN-1:0]   acc_hi, acc_lo, operand_q;
   logic [XLEN-1:0]   acc_hi_step, acc_lo_step;
   logic [CNT_W-1:0]  counter;
   logic              neg_q, rem_neg_q;
   logic              a_signed, b_signed, a_neg, b_neg;
   logic              div_zero, div_ovf, special, accept, last_step;
   logic [XLEN-1:0]   a_mag, b_mag, special_result;
   logic [XLEN-1:0]   quotient, remainder, final_result;
   logic [2*XLEN-1:0] product, product_fixed;

   assign op_in     = m_funct3_t'(funct3);
   assign accept    = (state == S_IDLE || state == S_DONE) && start && !flush;
   assign last_step = (counter == CNT_W'(1));

   // Operand conditioning and early-out detection for a request presented this cycle.
   always_comb begin
      a_signed = (op_in == M_MULH) || (op_in == M_MULHSU) || (op_in == M_DIV) || (op_in == M_REM);
      b_signed = (op_in == M_MULH) || (op_in == M_DIV) || (op_in == M_REM);
      a_neg    = a_signed && a[XLEN-1];
      b_neg    = b_signed && b[XLEN-1];
      a_mag    = a_neg ? -a : a;
      b_mag    = b_neg ? -b : b;
      div_zero = is_div_op(op_in) && (b == '0);
      div_ovf  = ((op_in == M_DIV) || (op_in == M_REM)) && (a == INT_MIN) && (b == '1);
      special  = div_zero || div_ovf;
      special_result = '0;
      if (div_zero) begin
         special_result = funct3[1] ? a : '1;
      end else if (div_ovf) begin
         special_result = funct3[1] ? '0 : INT_MIN;
      end
   end

   muldiv_step #(
      .XLEN     (XLEN),
      .MUL_STEP (MUL_STEP)
   ) u_step (
      .div_mode    (state == S_DIV),
      .acc_hi      (acc_hi),
      .acc_lo      (acc_lo),
      .operand     (operand_q),
      .acc_hi_next (acc_hi_step),
      .acc_lo_next (acc_lo_step)
   );

   // Sign correction on the final step's output, registered as the result on entry to DONE.
   always_comb begin
      product       = {acc_hi_step, acc_lo_step};
      product_fixed = neg_q ? -product : product;
      quotient      = neg_q ? -acc_lo_step : acc_lo_step;
      remainder     = rem_neg_q ? -acc_hi_step : acc_hi_step;
      case (op_q)
         M_MUL:                    final_result = product_fixed[XLEN-1:0];
         M_MULH, M_MULHSU, M_MULHU: final_result = product_fixed[2*XLEN-1:XLEN];
         M_DIV, M_DIVU:            final_result = quotient;
         default:                  final_result = remainder;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            done = (state == S_DONE) && !flush;
            if (accept) begin
               if (special) begin
                  state_next = S_DONE;
               end else if (funct3[2]) begin
                  state_next = S_DIV;
               end else begin
                  state_next = S_MUL;
               end
            end else begin
               state_next = S_IDLE;
            end
         end
         S_MUL, S_DIV: begin
            busy = 1'b1;
            if (flush) begin
               state_next = S_IDLE;
            end else if (last_step) begin
               state_next = S_DONE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // A flushed op never reaches the result register, so result keeps the last completed value.
   always_ff @(posedge clk) begin
      if (!rst) begin
         op_q      <= M_MUL;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         acc_hi    <= '0;
         acc_lo    <= '0;
         operand_q <= '0;
         counter   <= '0;
         result    <= '0;
      end else if (accept) begin
         op_q      <= op_in;
         neg_q     <= a_neg ^ b_neg;
         rem_neg_q <= a_neg;
         acc_hi    <= '0;
         if (funct3[2]) begin
            acc_lo    <= a_mag;
            operand_q <= b_mag;
            counter   <= CNT_W'(XLEN);
         end else begin
            acc_lo    <= b_mag;
            operand_q <= a_mag;
            counter   <= CNT_W'(MUL_CYCLES);
         end
         if (special) begin
            result <= special_result;
         end
      end else if ((state == S_MUL || state == S_DIV) && !flush) begin
         acc_hi  <= acc_hi_step;
         acc_lo  <= acc_lo_step;
         counter <= counter - CNT_W'(1);
         if (last_step) begin
            result <= final_result;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected result, done cycle and
// busy length; per-instance monitors pop and compare whenever done is seen.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   typedef struct {
      logic [31:0] value;
      int          due;
      int          busy_len;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0, flush = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] a = '0, b = '0;
   logic        busy, done;
   logic [31:0] result;

   logic        start4 = 1'b0, flush4 = 1'b0;
   logic [2:0]  funct3_4 = 3'd0;
   logic [31:0] a4 = '0, b4 = '0;
   logic        busy4, done4;
   logic [31:0] result4;

   exp_t sb_q[$];
   exp_t sb4_q[$];
   exp_t mon_e, mon4_e;
   int   errors = 0, checks = 0, cyc = 0;
   int   busy_run = 0, busy_run4 = 0;
   int   t = 0;

   muldiv_unit #(.XLEN(32), .MUL_STEP(1)) dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3), .a(a), .b(b),
      .flush(flush), .busy(busy), .done(done), .result(result)
   );

   muldiv_unit #(.XLEN(32), .MUL_STEP(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .funct3(funct3_4), .a(a4), .b(b4),
      .flush(flush4), .busy(busy4), .done(done4), .result(result4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         if (sb_q.size() == 0) begin
            checkOutput("spurious done", 32'(done), 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            checkOutput({mon_e.name, " result"}, result, mon_e.value);
            checkOutput({mon_e.name, " done cycle"}, 32'(cyc), 32'(mon_e.due));
            checkOutput({mon_e.name, " busy cycles"}, 32'(busy_run), 32'(mon_e.busy_len));
         end
         busy_run = 0;
      end else if (busy) begin
         busy_run++;
      end else begin
         busy_run = 0;
      end
   end

   always @(negedge clk) begin
      if (done4) begin
         if (sb4_q.size() == 0) begin
            checkOutput("step4 spurious done", 32'(done4), 32'd0);
         end else begin
            mon4_e = sb4_q.pop_front();
            checkOutput({mon4_e.name, " result"}, result4, mon4_e.value);
            checkOutput({mon4_e.name, " done cycle"}, 32'(cyc), 32'(mon4_e.due));
            checkOutput({mon4_e.name, " busy cycles"}, 32'(busy_run4), 32'(mon4_e.busy_len));
         end
         busy_run4 = 0;
      end else if (busy4) begin
         busy_run4++;
      end else begin
         busy_run4 = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitUntil(input int target);
      while (cyc < target) tick();
   endtask

   task automatic issueOp(input m_funct3_t f, input logic [31:0] av, input logic [31:0] bv);
      start  = 1'b1;
      funct3 = f;
      a      = av;
      b      = bv;
      tick();
      start  = 1'b0;
      funct3 = ~f;
      a      = ~av;
      b      = bv ^ 32'h5A5A_5A5A;
   endtask

   task automatic applyStimulus(input m_funct3_t f, input logic [31:0] av, input logic [31:0] bv,
                                input logic [31:0] expv, input int lat, input string nm);
      int t0;
      t0 = cyc;
      sb_q.push_back('{value: expv, due: t0 + lat, busy_len: (lat > 1) ? lat - 1 : 0, name: nm});
      issueOp(f, av, bv);
      waitUntil(t0 + lat + 1);
   endtask

   task automatic applyStimulus4(input m_funct3_t f, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] expv, input int lat, input string nm);
      int t0;
      t0 = cyc;
      sb4_q.push_back('{value: expv, due: t0 + lat, busy_len: lat - 1, name: nm});
      start4   = 1'b1;
      funct3_4 = f;
      a4       = av;
      b4       = bv;
      tick();
      start4   = 1'b0;
      a4       = '1;
      b4       = '1;
      waitUntil(t0 + lat + 1);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (3) tick();
      rst = 1'b1;
      tick();
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset result", result, 32'd0);
      checkOutput("reset result step4", result4, 32'd0);

      applyStimulus(M_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "MUL 7*-3");
      applyStimulus(M_MUL,    32'h1234_5678, 32'h10,        32'h2345_6780, 33, "MUL pos");
      applyStimulus(M_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "MULH min*min");
      applyStimulus(M_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU max*max");
      applyStimulus(M_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, "MULHSU -1*2");
      applyStimulus(M_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "DIV -7/2");
      applyStimulus(M_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "REM -7/2");
      applyStimulus(M_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "DIV 7/-2");
      applyStimulus(M_DIVU,   32'd100,       32'd7,         32'd14,        33, "DIVU 100/7");
      applyStimulus(M_REMU,   32'd100,       32'd7,         32'd2,         33, "REMU 100/7");
      applyStimulus(M_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33, "DIVU max/1");
      applyStimulus(M_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1,  "DIV by zero");
      applyStimulus(M_REMU,   32'd5,         32'd0,         32'd5,         1,  "REMU by zero");
      applyStimulus(M_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "DIV overflow");
      applyStimulus(M_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  "REM overflow");
      applyStimulus(M_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         33, "REM 7/-2");

      // Flush a multiply mid-flight: no done, result stays 1, then a fresh divide completes.
      t = cyc;
      issueOp(M_MUL, 32'd3, 32'd5);
      waitUntil(t + 10);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("flush busy cleared", 32'(busy), 32'd0);
      checkOutput("flush result held", result, 32'd1);
      applyStimulus(M_DIVU, 32'd1000, 32'd10, 32'd100, 33, "DIVU after flush");

      // A start while busy must be ignored.
      t = cyc;
      sb_q.push_back('{value: 32'd14, due: t + 33, busy_len: 32, name: "DIVU ignored start"});
      issueOp(M_DIVU, 32'd100, 32'd7);
      waitUntil(t + 3);
      issueOp(M_REMU, 32'd5, 32'd0);
      waitUntil(t + 34);

      // Reset in the middle of a divide clears everything the following cycle.
      t = cyc;
      issueOp(M_DIV, 32'hFFFF_FFF9, 32'd2);
      waitUntil(t + 5);
      rst = 1'b0;
      tick();
      checkOutput("midop reset busy", 32'(busy), 32'd0);
      checkOutput("midop reset done", 32'(done), 32'd0);
      checkOutput("midop reset result", result, 32'd0);
      rst = 1'b1;
      repeat (40) tick();
      checkOutput("post reset busy", 32'(busy), 32'd0);

      applyStimulus4(M_MUL,   32'h1234_5678, 32'h10,        32'h2345_6780, 9, "step4 MUL");
      applyStimulus4(M_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 9, "step4 MULHU");
      applyStimulus4(M_MULH,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 9, "step4 MULH -7*3");

      t = cyc;
      while ((sb_q.size() != 0 || sb4_q.size() != 0) && cyc < t + 100) tick();
      checkOutput("scoreboard drained", 32'(sb_q.size()), 32'd0);
      checkOutput("step4 scoreboard drained", 32'(sb4_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
